// File: rtl/angstrom_pkg.sv
// Shared definitions for the angstrom core: opcode encodings and fetch FSM states.
package angstrom_pkg;

    localparam int unsigned OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_LDI = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_STA = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_INP = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_BRC = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_BRZ = 4'd6;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'd7;
    localparam logic [OPCODE_W-1:0] OP_ADI = 4'd8;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'd9;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'd10;
    localparam logic [OPCODE_W-1:0] OP_AND = 4'd11;
    localparam logic [OPCODE_W-1:0] OP_ORR = 4'd12;
    localparam logic [OPCODE_W-1:0] OP_XOR = 4'd13;
    localparam logic [OPCODE_W-1:0] OP_LSL = 4'd14;
    localparam logic [OPCODE_W-1:0] OP_LSR = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter: synchronous reset, increment with wrap, branch-target load.
module fetch_pc #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next PC: a branch load wins; increment wraps naturally at 2^ADDR_W.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= ADDR_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/issue sequencer: PC, imem request/ack handshake, instruction register.
// Optional feature macro: FETCH_RETIRE_CNT_EN adds a 16-bit retired-instruction counter.
// OPR_W must not exceed ADDR_W (branch target is the zero-extended operand).
module fetch_unit
    import angstrom_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned OPR_W    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    output logic                      imem_req,
    output logic [ADDR_W-1:0]         imem_addr,
    input  logic                      imem_ack,
    input  logic [OPCODE_W+OPR_W-1:0] imem_data,
    output logic [OPCODE_W-1:0]       ir_opcode,
    output logic [OPR_W-1:0]          ir_operand,
    output logic                      ir_valid,
    input  logic                      exec_done,
    input  logic                      br_taken,
    output logic [ADDR_W-1:0]         pc,
    output logic                      busy
`ifdef FETCH_RETIRE_CNT_EN
    ,
    output logic [15:0]               retire_cnt
`endif
);

    fetch_state_e          state_q;
    logic [OPCODE_W-1:0]   ir_opcode_q;
    logic [OPR_W-1:0]      ir_operand_q;
    logic                  ir_valid_q;
    logic                  imem_req_q;
    logic                  busy_q;

    logic                  pc_inc;
    logic                  pc_load;
    logic                  retire;

    // PC strobes: advance on a completed fetch, redirect on a taken branch at retire.
    assign retire  = (state_q == ISSUE) && exec_done;
    assign pc_inc  = (state_q == FETCH) && imem_ack;
    assign pc_load = retire && br_taken;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (pc_inc),
        .load_i     (pc_load),
        .load_val_i (ADDR_W'(ir_operand_q)),
        .pc_o       (pc)
    );

    // Sequencer FSM with registered handshake, IR and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ir_opcode_q  <= '0;
            ir_operand_q <= '0;
            ir_valid_q   <= 1'b0;
            imem_req_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q    <= FETCH;
                        imem_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        ir_opcode_q  <= imem_data[OPCODE_W+OPR_W-1:OPR_W];
                        ir_operand_q <= imem_data[OPR_W-1:0];
                        ir_valid_q   <= 1'b1;
                        imem_req_q   <= 1'b0;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (exec_done) begin
                        ir_valid_q <= 1'b0;
                        if (run) begin
                            state_q    <= FETCH;
                            imem_req_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ir_valid_q <= 1'b0;
                    imem_req_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_RETIRE_CNT_EN
    logic [15:0] retire_cnt_q;

    // Retired-instruction counter, wraps at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (retire) begin
            retire_cnt_q <= retire_cnt_q + 16'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc;
    assign ir_opcode  = ir_opcode_q;
    assign ir_operand = ir_operand_q;
    assign ir_valid   = ir_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table plus directed multi-cycle sequences.
module tb_fetch_unit;

    logic       clk;
    logic       rst;

    // Main instance, ADDR_W=8.
    logic       run;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [3:0] ir_opcode;
    logic [3:0] ir_operand;
    logic       ir_valid;
    logic       exec_done;
    logic       br_taken;
    logic [7:0] pc;
    logic       busy;

    // Narrow instance, ADDR_W=4, for PC wrap.
    logic       w_run;
    logic       w_imem_req;
    logic [3:0] w_imem_addr;
    logic       w_imem_ack;
    logic [7:0] w_imem_data;
    logic [3:0] w_ir_opcode;
    logic [3:0] w_ir_operand;
    logic       w_ir_valid;
    logic       w_exec_done;
    logic       w_br_taken;
    logic [3:0] w_pc;
    logic       w_busy;

`ifdef FETCH_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
    logic [15:0] w_retire_cnt;
`endif

    int checks;
    int errors;

    fetch_unit #(.ADDR_W(8), .OPR_W(4), .RESET_PC(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .ir_opcode  (ir_opcode),
        .ir_operand (ir_operand),
        .ir_valid   (ir_valid),
        .exec_done  (exec_done),
        .br_taken   (br_taken),
        .pc         (pc),
        .busy       (busy)
`ifdef FETCH_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    fetch_unit #(.ADDR_W(4), .OPR_W(4), .RESET_PC(0)) dut_w (
        .clk        (clk),
        .rst        (rst),
        .run        (w_run),
        .imem_req   (w_imem_req),
        .imem_addr  (w_imem_addr),
        .imem_ack   (w_imem_ack),
        .imem_data  (w_imem_data),
        .ir_opcode  (w_ir_opcode),
        .ir_operand (w_ir_operand),
        .ir_valid   (w_ir_valid),
        .exec_done  (w_exec_done),
        .br_taken   (w_br_taken),
        .pc         (w_pc),
        .busy       (w_busy)
`ifdef FETCH_RETIRE_CNT_EN
        ,
        .retire_cnt (w_retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic       ack;
        logic [7:0] data;
        logic       ed;
        logic       br;
        logic       req;
        logic [7:0] addr;
        logic [3:0] op;
        logic [3:0] opr;
        logic       valid;
        logic [7:0] pc;
        logic       busy;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive main-instance inputs for one cycle, then sample 1ns after the edge.
    task automatic step(input logic r, input logic rn, input logic ak, input logic [7:0] d,
                        input logic ed, input logic br);
        rst       = r;
        run       = rn;
        imem_ack  = ak;
        imem_data = d;
        exec_done = ed;
        br_taken  = br;
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic req, input logic [7:0] addr,
                              input logic [3:0] op, input logic [3:0] opr, input logic valid,
                              input logic [7:0] pcv, input logic bsy);
        check({tag, ".imem_req"},   32'(imem_req),   32'(req));
        check({tag, ".imem_addr"},  32'(imem_addr),  32'(addr));
        check({tag, ".ir_opcode"},  32'(ir_opcode),  32'(op));
        check({tag, ".ir_operand"}, 32'(ir_operand), 32'(opr));
        check({tag, ".ir_valid"},   32'(ir_valid),   32'(valid));
        check({tag, ".pc"},         32'(pc),         32'(pcv));
        check({tag, ".busy"},       32'(busy),       32'(bsy));
    endtask

    task automatic wstep(input logic rn, input logic ak, input logic [7:0] d,
                         input logic ed, input logic br);
        w_run       = rn;
        w_imem_ack  = ak;
        w_imem_data = d;
        w_exec_done = ed;
        w_br_taken  = br;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //            run ack data   ed br | req addr   op    opr   v  pc     busy
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 4'h0, 4'h0, 1'b0, 8'h00, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 4'h0, 4'h0, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0, 8'h01, 4'h1, 4'h5, 1'b1, 8'h01, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01, 4'h1, 4'h5, 1'b1, 8'h01, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 4'h1, 4'h5, 1'b0, 8'h01, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 8'h02, 4'h0, 4'h4, 1'b1, 8'h02, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 4'h0, 4'h4, 1'b0, 8'h04, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 8'h73, 1'b0, 1'b0, 1'b0, 8'h05, 4'h7, 4'h3, 1'b1, 8'h05, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 4'h7, 4'h3, 1'b0, 8'h03, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 8'h74, 1'b0, 1'b0, 1'b0, 8'h04, 4'h7, 4'h4, 1'b1, 8'h04, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 4'h7, 4'h4, 1'b0, 8'h04, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 8'h73, 1'b0, 1'b0, 1'b0, 8'h05, 4'h7, 4'h3, 1'b1, 8'h05, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h05, 4'h7, 4'h3, 1'b0, 8'h05, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b0, 8'h06, 4'h2, 4'hA, 1'b1, 8'h06, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h06, 4'h2, 4'hA, 1'b1, 8'h06, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h06, 4'h2, 4'hA, 1'b0, 8'h06, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h06, 4'h2, 4'hA, 1'b0, 8'h06, 1'b0};

        w_run = 1'b0; w_imem_ack = 1'b0; w_imem_data = 8'h00; w_exec_done = 1'b0; w_br_taken = 1'b0;

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
        check_main("reset", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
`ifdef FETCH_RETIRE_CNT_EN
        check("reset.retire_cnt", 32'(retire_cnt), 32'd0);
`endif

        // Table: first fetch, stray br_taken, JMP taken/not taken, stray ack, run drop.
        for (int i = 0; i < NVEC; i++) begin
            step(1'b0, vecs[i].run, vecs[i].ack, vecs[i].data, vecs[i].ed, vecs[i].br);
            check_main($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].op,
                       vecs[i].opr, vecs[i].valid, vecs[i].pc, vecs[i].busy);
        end
`ifdef FETCH_RETIRE_CNT_EN
        check("table.retire_cnt", 32'(retire_cnt), 32'd6);
`endif

        // run dropped in FETCH, ack delayed three cycles.
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_main("slow.f1", 1'b1, 8'h06, 4'h2, 4'hA, 1'b0, 8'h06, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_main("slow.f2", 1'b1, 8'h06, 4'h2, 4'hA, 1'b0, 8'h06, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_main("slow.f3", 1'b1, 8'h06, 4'h2, 4'hA, 1'b0, 8'h06, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        check_main("slow.issue", 1'b0, 8'h07, 4'h1, 4'h1, 1'b1, 8'h07, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_main("slow.idle", 1'b0, 8'h07, 4'h1, 4'h1, 1'b0, 8'h07, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            check_main($sformatf("slow.stay%0d", i), 1'b0, 8'h07, 4'h1, 4'h1, 1'b0, 8'h07, 1'b0);
        end
`ifdef FETCH_RETIRE_CNT_EN
        check("slow.retire_cnt", 32'(retire_cnt), 32'd7);
`endif

        // Reset during ISSUE.
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_main("r6.fetch", 1'b1, 8'h07, 4'h1, 4'h1, 1'b0, 8'h07, 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h9C, 1'b0, 1'b0);
        check_main("r6.issue", 1'b0, 8'h08, 4'h9, 4'hC, 1'b1, 8'h08, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        check_main("r6.rst_issue", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
`ifdef FETCH_RETIRE_CNT_EN
        check("r6.retire_cnt", 32'(retire_cnt), 32'd0);
`endif

        // Reset during FETCH with a simultaneous ack, then a late ack.
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_main("r6.fetch2", 1'b1, 8'h00, 4'h0, 4'h0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'h9C, 1'b0, 1'b0);
        check_main("r6.rst_fetch", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h9C, 1'b0, 1'b0);
        check_main("r6.late_ack", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);

        // PC wrap on the 4-bit instance: JMP 15, fetch there, PC wraps to 0.
        wstep(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("wrap.req0", 32'(w_imem_req), 32'd1);
        check("wrap.addr0", 32'(w_imem_addr), 32'd0);
        wstep(1'b1, 1'b1, 8'h7F, 1'b0, 1'b0);
        check("wrap.pc1", 32'(w_pc), 32'd1);
        check("wrap.opr", 32'(w_ir_operand), 32'hF);
        wstep(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        check("wrap.addr15", 32'(w_imem_addr), 32'hF);
        check("wrap.req15", 32'(w_imem_req), 32'd1);
        wstep(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        check("wrap.pc_wrapped", 32'(w_pc), 32'd0);
        check("wrap.valid", 32'(w_ir_valid), 32'd1);
        wstep(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("wrap.next_req", 32'(w_imem_req), 32'd1);
        check("wrap.next_addr", 32'(w_imem_addr), 32'd0);
        wstep(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch/issue sequencer. It produces the 4-bit opcode that the control unit decodes.
- Holds the PC and runs a request/acknowledge read of instruction memory.
- Latches the fetched word into an instruction register and presents opcode/operand with a valid flag.
- Waits for the datapath to finish executing before it fetches again.
- Applies a branch redirect when the datapath reports one.

Parameters:
ADDR_W, 8, PC / instruction-memory address width
OPR_W, 4, operand field width; instruction width = 4+OPR_W; OPR_W <= ADDR_W required
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; synchronous, active-high
run  in  1  level; enables fetching of new instructions
imem_req  out  1  instruction read request
imem_addr  out  ADDR_W  read address, equals pc while imem_req=1
imem_ack  in  1  read data valid this cycle
imem_data  in  4+OPR_W  instruction word; [3+OPR_W:OPR_W] opcode, [OPR_W-1:0] operand
ir_opcode  out  4  latched opcode, to the control unit
ir_operand  out  OPR_W  latched operand (immediate or branch target)
ir_valid  out  1  instruction register holds an instruction being executed
exec_done  in  1  datapath has finished the instruction currently in IR
br_taken  in  1  branch taken; meaningful only while exec_done=1
pc  out  ADDR_W  current program counter
busy  out  1  state != IDLE

Behaviour:
- Reset values (rst=1 at a clock edge): state IDLE, pc=RESET_PC, ir_opcode=0, ir_operand=0, ir_valid=0, imem_req=0, busy=0. Reset overrides every other input, including mid-FETCH and mid-ISSUE; an outstanding request is abandoned and a late imem_ack is ignored.
- All outputs are registered except imem_addr, which is a direct copy of pc.
- IDLE: imem_req=0, ir_valid=0. If run=1, go to FETCH next cycle.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - imem_ack may arrive in the first FETCH cycle or any number of cycles later.
  - On imem_ack, at that edge: latch opcode/operand, pc <= pc+1 modulo 2^ADDR_W (wraps to 0), imem_req <= 0, ir_valid <= 1, go to ISSUE.
  - run falling during FETCH does not abort the fetch.
- ISSUE:
  - ir_valid=1; ir_opcode and ir_operand are stable for the whole state.
  - exec_done is honoured from the first ISSUE cycle.
  - On exec_done: ir_valid <= 0.
    - If br_taken=1, pc <= zero-extended ir_operand.
    - Else pc keeps its incremented value.
    - Next state is FETCH if run=1 at that edge, else IDLE.
  - br_taken with exec_done=0 is ignored.
  - imem_ack outside FETCH is ignored.
- Throughput: at most one instruction per 2 cycles (FETCH with immediate ack + ISSUE with immediate exec_done).
- No opcode is interpreted inside the block. Branch condition evaluation (carry/zero) belongs to the datapath.

Optional Feature:
FETCH_RETIRE_CNT_EN
- Defined: adds output retire_cnt [15:0].
  - Reset to 0.
  - Increments by 1 at every edge where state=ISSUE and exec_done=1.
  - Wraps 0xFFFF -> 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package angstrom_pkg:
  - OPCODE_W=4.
  - Opcode constants OP_LDA(0), OP_LDI(1), OP_STA(2), OP_INP(3), OP_OUT(4), OP_BRC(5), OP_BRZ(6), OP_JMP(7), OP_ADI(8), OP_ADD(9), OP_SUB(10), OP_AND(11), OP_ORR(12), OP_XOR(13), OP_LSL(14), OP_LSR(15).
  - Fetch state enum IDLE/FETCH/ISSUE.
- One sub-module, fetch_pc: the PC register with synchronous reset to RESET_PC, increment-with-wrap, and load of the branch target. The top level holds the FSM and the instruction register.

Test Plan:
1. Release rst, run=1, imem_ack one cycle after imem_req, imem_data=0x15 at addr 0 -> imem_addr=0 while requested; then ir_opcode=1, ir_operand=5, ir_valid=1, pc=1.
2. JMP: imem_data=0x73 fetched from addr 4; exec_done=1, br_taken=1 -> next imem_req with imem_addr=3. Same with br_taken=0 -> imem_addr=5.
3. br_taken=1 pulsed while exec_done=0 during ISSUE -> no pc change; ir_valid stays 1.
4. PC wrap, ADDR_W=4: fetch at pc=15 -> pc=0 after ack, next request at addr 0.
5. run dropped in FETCH with ack delayed 3 cycles -> imem_req and imem_addr held 3 cycles; ISSUE completes on exec_done; then IDLE, no further imem_req, busy=0.
6. rst asserted in ISSUE, then in FETCH with imem_ack in the same cycle -> next cycle ir_valid=0, imem_req=0, pc=RESET_PC, IR unchanged from 0. With FETCH_RETIRE_CNT_EN: retire_cnt=0.
